// File: rtl/ycbcr422_to_444.sv
// 4:2:2 to 4:4:4 chroma upsampler: each horizontal pixel pair shares one Cb and one Cr
// (co-sited replication), fixed 2-cycle latency with valid/hs/vs kept aligned.
module ycbcr422_to_444 #(
    parameter int                DATA_W      = 8,
    parameter bit                CB_FIRST    = 1'b1,
    parameter logic [DATA_W-1:0] CHROMA_FILL = 8'd128
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              in_valid,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_c,
    output logic [DATA_W-1:0] y_8b_o,
    output logic [DATA_W-1:0] cb_8b_o,
    output logic [DATA_W-1:0] cr_8b_o,
    output logic              ycbcr_valid,
    output logic              ycbcr_hs,
    output logic              ycbcr_vs
);

    function automatic logic [DATA_W-1:0] route_cb(input logic [DATA_W-1:0] first_c,
                                                   input logic [DATA_W-1:0] second_c);
        return CB_FIRST ? first_c : second_c;
    endfunction

    function automatic logic [DATA_W-1:0] route_cr(input logic [DATA_W-1:0] first_c,
                                                   input logic [DATA_W-1:0] second_c);
        return CB_FIRST ? second_c : first_c;
    endfunction

    logic              ph;
    logic [DATA_W-1:0] y_p1;
    logic [DATA_W-1:0] c_p1;
    logic              ph_p1;
    logic              vld_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic [DATA_W-1:0] hold_c_p2;

    logic [DATA_W-1:0] first_c;
    logic [DATA_W-1:0] second_c;
    logic [DATA_W-1:0] y_nxt;
    logic [DATA_W-1:0] cb_nxt;
    logic [DATA_W-1:0] cr_nxt;
    logic              vld_nxt;

    // Stage 1: phase tracking and input capture
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ph     <= 1'b0;
            y_p1   <= '0;
            c_p1   <= '0;
            ph_p1  <= 1'b0;
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            ph     <= in_valid ? ~ph : 1'b0;
            y_p1   <= in_y;
            c_p1   <= in_c;
            ph_p1  <= ph;
            vld_p1 <= in_valid;
            hs_p1  <= in_hs;
            vs_p1  <= in_vs;
        end
    end

    // A first sample borrows its partner straight from the input; a lone one gets the fill value.
    always_comb begin
        first_c  = '0;
        second_c = '0;
        y_nxt    = '0;
        vld_nxt  = 1'b0;
        if (vld_p1) begin
            y_nxt   = y_p1;
            vld_nxt = 1'b1;
            if (!ph_p1) begin
                first_c  = c_p1;
                second_c = in_valid ? in_c : CHROMA_FILL;
            end else begin
                first_c  = hold_c_p2;
                second_c = c_p1;
            end
        end
        cb_nxt = vld_p1 ? route_cb(first_c, second_c) : '0;
        cr_nxt = vld_p1 ? route_cr(first_c, second_c) : '0;
    end

    // Stage 2: output registers and pair chroma hold
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            y_8b_o      <= '0;
            cb_8b_o     <= '0;
            cr_8b_o     <= '0;
            ycbcr_valid <= 1'b0;
            ycbcr_hs    <= 1'b0;
            ycbcr_vs    <= 1'b0;
            hold_c_p2   <= '0;
        end else begin
            y_8b_o      <= y_nxt;
            cb_8b_o     <= cb_nxt;
            cr_8b_o     <= cr_nxt;
            ycbcr_valid <= vld_nxt;
            ycbcr_hs    <= hs_p1;
            ycbcr_vs    <= vs_p1;
            if (vld_p1 && !ph_p1) begin
                hold_c_p2 <= c_p1;
            end
        end
    end

endmodule

// File: doc/ycbcr422_to_444.md
# ycbcr422_to_444

Chroma upsampler that sits directly upstream of the YCbCr-to-RGB converter. It accepts a 4:2:2 stream of one Y plus one alternating Cb/Cr sample per clock, and emits full 4:4:4 Y/Cb/Cr pixels with valid/hs/vs aligned, at a fixed 2-cycle latency. Each horizontal pixel pair shares one Cb and one Cr (co-sited replication, no interpolation), so its output feeds the converter's `y_8b_i`/`cb_8b_i`/`cr_8b_i` ports without glue logic.

## Interface
- CB_FIRST, 1, 1: the first valid sample of a run carries Cb; 0: it carries Cr.
- CHROMA_FILL, 8'd128, chroma value substituted for a missing partner sample (odd-length run).
- clk  in  1  clock.
- reset_p  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_hs  in  1  input line sync, passed through.
- in_vs  in  1  input frame sync, passed through.
- in_y  in  8  luma sample.
- in_c  in  8  interleaved chroma sample (Cb/Cr alternating).
- y_8b_o  out  8  luma out.
- cb_8b_o  out  8  Cb out.
- cr_8b_o  out  8  Cr out.
- ycbcr_valid  out  1  output pixel valid.
- ycbcr_hs  out  1  in_hs delayed 2 cycles.
- ycbcr_vs  out  1  in_vs delayed 2 cycles.

## Operation
- Phase bit `ph`:
  - Cleared to 0 on any cycle with in_valid=0.
  - Toggles on every cycle with in_valid=1.
  - A run of consecutive valid cycles therefore always starts at ph=0.
  - ph=0 marks a "first" sample, ph=1 a "second" sample.
- Chroma mapping:
  - With CB_FIRST=1, the ph=0 in_c is Cb and the ph=1 in_c is Cr.
  - With CB_FIRST=0, the two are swapped.
- Stage 1 register (s1) captures in_y, in_c, ph, in_valid, in_hs and in_vs every cycle.
- Chroma hold register: when s1 holds a valid ph=0 sample, the output stage latches the pair's first chroma sample for reuse by the ph=1 partner.
- Stage 2 (outputs), evaluated each cycle from s1 and the current input:
  - s1 valid, ph=0, in_valid=1 (partner present this cycle): Y=s1.y; first chroma=s1.c; second chroma=in_c.
  - s1 valid, ph=0, in_valid=0 (odd trailing sample): Y=s1.y; first chroma=s1.c; second chroma=CHROMA_FILL.
  - s1 valid, ph=1: Y=s1.y; first chroma=held value; second chroma=s1.c.
  - s1 invalid: y/cb/cr outputs forced to 0, ycbcr_valid=0.
- Outputs the first/second chroma to cb/cr according to CB_FIRST.
- A partner sample is taken from in_c in the same cycle the second sample is captured into s1. The ph=1 pixel then reuses the hold register, so both pixels of a pair carry identical Cb and Cr.
- ycbcr_hs and ycbcr_vs are pure 2-stage delays. They are never gated by valid.
- No backpressure: the block accepts and emits one pixel every cycle.

## Timing
- Latency: input sample at cycle t appears on the outputs at t+2 for every sample. Throughput is 1 pixel per clock.
- Reset (async assert, synchronous deassert at the system level) clears to 0:
  - all outputs (y/cb/cr outputs, ycbcr_valid, ycbcr_hs, ycbcr_vs);
  - s1, ph and the hold register.
- Reset asserted mid-line: the partial pair is discarded. The first valid sample after release is treated as ph=0.
- A single-cycle in_valid gap in a line restarts pairing at ph=0 on the next valid cycle. The pixel before the gap, if ph=0, is emitted with CHROMA_FILL.
- Simultaneous events:
  - in_hs/in_vs edges coinciding with valid transitions require no special handling.
  - Syncs and valid stay cycle-aligned after the 2-cycle delay.

## Test plan
- Reset: hold reset_p=1 with random inputs → all outputs 0; release, then 2 idle cycles → outputs remain 0.
- Basic pair, CB_FIRST=1: (Y=10,C=90),(Y=20,C=200) on consecutive cycles at t0,t0+1 → t0+2: (10,90,200) valid; t0+3: (20,90,200) valid; t0+4: valid=0, data 0.
- Odd run: 3 valid samples (Y=1,C=50),(Y=2,C=60),(Y=3,C=70), then idle → outputs (1,50,60),(2,50,60),(3,70,128).
- Gap restarts phase: samples A,B, gap, C,D → C is treated as Cb and D as Cr; no chroma leaks from A/B into C/D.
- CB_FIRST=0: pair (Y=10,C=90),(Y=20,C=200) → cb=200, cr=90 on both output pixels.
- Full 640-pixel line streamed with hs/vs toggling → ycbcr_hs/ycbcr_vs equal the inputs delayed exactly 2 cycles; 640 valid outputs; chroma matches a reference model. Assert reset_p at pixel 301 → outputs zero immediately, and the next line pairs correctly.
